// File: rtl/axis_sa_feeder.sv
`default_nettype none
// ============================================================================
// Module      : axis_sa_feeder
// Description : Joins an X-row operand stream and a K-column operand stream
//               into a single beat stream for the systolic-array slave port.
//               Marks the Len-th beat of each tile with last. The tile length
//               is loaded through a cfg handshake that is open only in IDLE.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i        in   1              clock, rising edge
//   rst_i        in   1              asynchronous reset, active-high
//   cfg_valid_i  in   1              tile config valid
//   cfg_ready_o  out  1              config accepted (high only in IDLE)
//   cfg_len_i    in   WidthLen       beats in next tile (0 treated as 1)
//   sx_valid_i   in   1              X beat valid
//   sx_ready_o   out  1              X beat accepted
//   sx_data_i    in   Rows*WidthX    X operands, row r at [r*WidthX +: WidthX]
//   sk_valid_i   in   1              K beat valid
//   sk_ready_o   out  1              K beat accepted
//   sk_data_i    in   Cols*WidthK    K operands, col c at [c*WidthK +: WidthK]
//   m_valid_o    out  1              joined beat valid
//   m_ready_i    in   1              downstream accepts beat
//   m_last_o     out  1              final beat of tile
//   mx_data_o    out  Rows*WidthX    registered X operands
//   mk_data_o    out  Cols*WidthK    registered K operands
//   busy_o       out  1              tile in progress (RUN)
// ============================================================================
module axis_sa_feeder #(
  parameter int Rows     = 4,
  parameter int Cols     = 8,
  parameter int WidthX   = 4,
  parameter int WidthK   = 8,
  parameter int WidthLen = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [WidthLen-1:0]    cfg_len_i,
  input  logic                   sx_valid_i,
  output logic                   sx_ready_o,
  input  logic [Rows*WidthX-1:0] sx_data_i,
  input  logic                   sk_valid_i,
  output logic                   sk_ready_o,
  input  logic [Cols*WidthK-1:0] sk_data_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   m_last_o,
  output logic [Rows*WidthX-1:0] mx_data_o,
  output logic [Cols*WidthK-1:0] mk_data_o,
  output logic                   busy_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                 state_q;
  logic [WidthLen-1:0]    len_q;
  logic [WidthLen-1:0]    cnt_q;
  logic                   m_valid_q;
  logic                   m_last_q;
  logic [Rows*WidthX-1:0] mx_q;
  logic [Cols*WidthK-1:0] mk_q;

  logic [WidthLen-1:0]    len_d;
  logic                   out_free;
  logic                   run;
  logic                   fire;
  logic                   is_last;

  // A zero length would never reach its last beat; clamp it to one.
  assign len_d    = (cfg_len_i == '0) ? WidthLen'(1) : cfg_len_i;

  assign run      = (state_q == RUN);
  assign out_free = !m_valid_q || m_ready_i;
  assign fire     = run && sx_valid_i && sk_valid_i && out_free;

  // Each stream's ready looks only at the opposite stream's valid, so both
  // streams are consumed in the same cycle and no ready->valid loop exists.
  assign sx_ready_o = run && sk_valid_i && out_free;
  assign sk_ready_o = run && sx_valid_i && out_free;

  // len_q is never zero, so len_q-1 cannot underflow.
  assign is_last  = (cnt_q == (len_q - WidthLen'(1)));

  assign cfg_ready_o = (state_q == IDLE);
  assign busy_o      = run;
  assign m_valid_o   = m_valid_q;
  assign m_last_o    = m_last_q;
  assign mx_data_o   = mx_q;
  assign mk_data_o   = mk_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      len_q     <= WidthLen'(1);
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      mx_q      <= '0;
      mk_q      <= '0;
    end else begin
      // Output slice: load on fire, hold while stalled, empty when drained.
      if (fire) begin
        mx_q      <= sx_data_i;
        mk_q      <= sk_data_i;
        m_valid_q <= 1'b1;
        m_last_q  <= is_last;
      end else if (m_ready_i) begin
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          // The previous tile's last beat may still sit in the slice here.
          if (cfg_valid_i) begin
            len_q   <= len_d;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (fire) begin
            if (is_last) begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q   <= cnt_q + WidthLen'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_sa_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_sa_feeder
// Description : Directed self-checking bench for axis_sa_feeder. Covers reset,
//               streaming, len=0 clamping, late K stream, downstream stall,
//               back-to-back tiles and asynchronous reset mid-tile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_sa_feeder;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_len;
  logic        sx_valid;
  logic        sx_ready;
  logic [15:0] sx_data;
  logic        sk_valid;
  logic        sk_ready;
  logic [63:0] sk_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [15:0] mx_data;
  logic [63:0] mk_data;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] lastpat;

  axis_sa_feeder #(
    .Rows(4), .Cols(8), .WidthX(4), .WidthK(8), .WidthLen(16)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready),
    .cfg_len_i  (cfg_len),
    .sx_valid_i (sx_valid),
    .sx_ready_o (sx_ready),
    .sx_data_i  (sx_data),
    .sk_valid_i (sk_valid),
    .sk_ready_o (sk_ready),
    .sk_data_i  (sk_data),
    .m_valid_o  (m_valid),
    .m_ready_i  (m_ready),
    .m_last_o   (m_last),
    .mx_data_o  (mx_data),
    .mk_data_o  (mk_data),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Registered outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] xv(input int i);
    return 16'hA000 + 16'(i);
  endfunction

  function automatic logic [63:0] kv(input int i);
    return 64'hC0DE_0000_0000_0000 + 64'(i);
  endfunction

  task automatic put(input int i);
    sx_data = xv(i);
    sk_data = kv(i);
  endtask

  task automatic cfg(input logic [15:0] len);
    cfg_valid = 1'b1;
    cfg_len   = len;
    #1;
    chk("cfg_ready_idle", cfg_ready, 1'b1);
    tick();
    cfg_valid = 1'b0;
    chk("busy_after_cfg", busy, 1'b1);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_len = '0;
    sx_valid = 1'b0; sx_data = '0; sk_valid = 1'b0; sk_data = '0;
    m_ready = 1'b1; lastpat = '0;

    // ---------------- reset ----------------
    tick(); tick();
    chk("rst_mvalid", m_valid, 1'b0);
    rst = 1'b0;
    tick();
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mlast", m_last, 1'b0);
    chk("rst_mx", mx_data, 64'h0);
    chk("rst_mk", mk_data, 64'h0);

    // ---------------- 1: len=4 streaming ----------------
    cfg(16'd4);
    sx_valid = 1'b1; sk_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(i);
      #1;
      chk("t1_sx_ready", sx_ready, 1'b1);
      tick();
      chk("t1_mvalid", m_valid, 1'b1);
      chk("t1_mx", mx_data, xv(i));
      chk("t1_mk", mk_data, kv(i));
      chk("t1_mlast", m_last, (i == 3));
      chk("t1_busy", busy, (i != 3));
    end
    sx_valid = 1'b0; sk_valid = 1'b0;
    tick();
    chk("t1_drain", m_valid, 1'b0);

    // ---------------- 2: len=0 treated as 1 ----------------
    for (int t = 0; t < 2; t++) begin
      cfg(16'd0);
      sx_valid = 1'b1; sk_valid = 1'b1; put(16 + t);
      tick();
      sx_valid = 1'b0; sk_valid = 1'b0;
      chk("t2_mvalid", m_valid, 1'b1);
      chk("t2_mlast", m_last, 1'b1);
      chk("t2_mx", mx_data, xv(16 + t));
      chk("t2_cfg_ready", cfg_ready, 1'b1);
      chk("t2_busy", busy, 1'b0);
    end

    // ---------------- 3: K stream late by 3 cycles ----------------
    cfg(16'd1);
    sx_valid = 1'b1; put(32);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t3_sx_ready_low", sx_ready, 1'b0);
      tick();
      chk("t3_no_beat", m_valid, 1'b0);
    end
    sk_valid = 1'b1;
    #1;
    chk("t3_sx_ready_high", sx_ready, 1'b1);
    chk("t3_sk_ready_high", sk_ready, 1'b1);
    tick();
    sx_valid = 1'b0; sk_valid = 1'b0;
    chk("t3_mvalid", m_valid, 1'b1);
    chk("t3_mx", mx_data, xv(32));
    chk("t3_mk", mk_data, kv(32));
    chk("t3_mlast", m_last, 1'b1);

    // ---------------- 4: stall mid-tile, len=8 ----------------
    cfg(16'd8);
    sx_valid = 1'b1; sk_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(i);
      tick();
      chk("t4_pre_mx", mx_data, xv(i));
    end
    m_ready = 1'b0; put(3);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4_stall_sx_ready", sx_ready, 1'b0);
      chk("t4_stall_sk_ready", sk_ready, 1'b0);
      tick();
      chk("t4_hold_valid", m_valid, 1'b1);
      chk("t4_hold_mx", mx_data, xv(2));
      chk("t4_hold_mk", mk_data, kv(2));
      chk("t4_hold_last", m_last, 1'b0);
    end
    m_ready = 1'b1;
    for (int i = 3; i < 8; i++) begin
      put(i);
      tick();
      chk("t4_mx", mx_data, xv(i));
      chk("t4_mk", mk_data, kv(i));
      chk("t4_mlast", m_last, (i == 7));
    end
    sx_valid = 1'b0; sk_valid = 1'b0;
    tick();
    chk("t4_drain", m_valid, 1'b0);

    // ---------------- 5: back-to-back len=3 then len=2 ----------------
    cfg(16'd3);
    sx_valid = 1'b1; sk_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(40 + i);
      tick();
      lastpat = {lastpat[3:0], m_last};
    end
    // Last beat of tile 1 now held; accept the next cfg meanwhile.
    sx_valid = 1'b0; sk_valid = 1'b0; m_ready = 1'b0;
    cfg_valid = 1'b1; cfg_len = 16'd2;
    #1;
    chk("t5_cfg_ready_overlap", cfg_ready, 1'b1);
    tick();
    cfg_valid = 1'b0;
    chk("t5_held_valid", m_valid, 1'b1);
    chk("t5_held_mx", mx_data, xv(42));
    chk("t5_held_last", m_last, 1'b1);
    chk("t5_busy", busy, 1'b1);
    sx_valid = 1'b1; sk_valid = 1'b1; put(43);
    #1;
    chk("t5_blocked", sx_ready, 1'b0);
    m_ready = 1'b1;
    #1;
    chk("t5_fire_on_drain", sx_ready, 1'b1);
    tick();
    lastpat = {lastpat[3:0], m_last};
    chk("t5_mx3", mx_data, xv(43));
    put(44);
    tick();
    lastpat = {lastpat[3:0], m_last};
    chk("t5_mx4", mx_data, xv(44));
    chk("t5_last_pattern", lastpat, 5'b00101);
    sx_valid = 1'b0; sk_valid = 1'b0;
    tick();

    // ---------------- 6: async reset mid-tile ----------------
    cfg(16'd6);
    sx_valid = 1'b1; sk_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      put(50 + i);
      tick();
    end
    put(52);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_mvalid", m_valid, 1'b0);
    chk("t6_async_mlast", m_last, 1'b0);
    chk("t6_async_mx", mx_data, 64'h0);
    chk("t6_async_busy", busy, 1'b0);
    chk("t6_async_cfg_ready", cfg_ready, 1'b1);
    sx_valid = 1'b0; sk_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    cfg(16'd2);
    sx_valid = 1'b1; sk_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      put(60 + i);
      tick();
      chk("t6_mx", mx_data, xv(60 + i));
      chk("t6_mlast", m_last, (i == 1));
    end
    chk("t6_busy_end", busy, 1'b0);
    sx_valid = 1'b0; sk_valid = 1'b0;
    tick();
    chk("t6_drain", m_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
